// File: rtl/risc_prog_loader.sv
// risc_prog_loader: byte-stream image loader that fills instruction memory, checks an XOR sum and gates core reset
module risc_prog_loader #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);
  localparam int DEPTH = 1 << ADDR_W;
  typedef enum logic [2:0] {S_CNT_HI, S_CNT_LO, S_DATA, S_WRITE, S_CHK, S_RUN, S_ERR} state_t;
  state_t state, nxt;
  logic [15:0] count;
  logic [ADDR_W:0] widx;
  logic [1:0] bidx;
  logic [7:0] xsum;
  logic [DATA_W-1:0] word;
  logic acc, last, restart;
  assign in_ready = state inside {S_CNT_HI, S_CNT_LO, S_DATA, S_CHK};
  assign acc = in_valid & in_ready;
  assign last = 16'(widx) == count - 16'd1;
  assign restart = reload & (state inside {S_RUN, S_ERR});
  assign imem_we = state == S_WRITE;
  assign imem_addr = widx[ADDR_W-1:0];
  assign imem_wdata = word;
  assign cpu_rst = state != S_RUN;
  assign load_done = state == S_RUN;
  assign load_err = state == S_ERR;
  always_comb begin
    nxt = state;
    case (state)
      S_CNT_HI: nxt = acc ? S_CNT_LO : S_CNT_HI;
      S_CNT_LO: if (acc) nxt = int'({count[15:8], in_byte}) > DEPTH ? S_ERR :
                               {count[15:8], in_byte} == 16'd0 ? S_CHK : S_DATA;
      S_DATA:   nxt = acc && bidx == 2'd3 ? S_WRITE : S_DATA;
      S_WRITE:  nxt = last ? S_CHK : S_DATA;
      S_CHK:    if (acc) nxt = in_byte == xsum ? S_RUN : S_ERR;
      default:  nxt = restart ? S_CNT_HI : state;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CNT_HI;
      count <= '0;
      widx  <= '0;
      bidx  <= '0;
      xsum  <= '0;
      word  <= '0;
    end else begin
      state <= nxt;
      if (acc && state != S_CHK) xsum <= xsum ^ in_byte;
      if (acc && state == S_CNT_HI) count[15:8] <= in_byte;
      if (acc && state == S_CNT_LO) count[7:0] <= in_byte;
      if (acc && state == S_DATA) begin
        word <= {word[DATA_W-9:0], in_byte};
        bidx <= bidx + 2'd1;
      end
      if (state == S_WRITE) widx <= widx + 1'b1;
      if (restart) begin
        widx <= '0;
        bidx <= '0;
        xsum <= '0;
      end
    end
  end
endmodule
